// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register file: NUM_REGS-NUM_RO read/write control registers plus NUM_RO read-only
// status registers. Write and read channels run as independent two-state FSMs.
module axil_regfile_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned NUM_RO     = 2
) (
    input  logic                                    ACLK,
    input  logic                                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]                   S_AXI_AWADDR,
    input  logic [2:0]                              S_AXI_AWPROT,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                 S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                   S_AXI_ARADDR,
    input  logic [2:0]                              S_AXI_ARPROT,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                   S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY,
    input  logic [NUM_RO*DATA_WIDTH-1:0]            status_in,
    output logic [(NUM_REGS-NUM_RO)*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_REGS-NUM_RO-1:0]              wr_pulse
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned NUM_RW   = NUM_REGS - NUM_RO;
    localparam int unsigned CTRL_W   = NUM_RW * DATA_WIDTH;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic [0:0] {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t             wr_state, wr_state_d;
    rd_state_t             rd_state, rd_state_d;

    logic                  aw_done, aw_done_d;
    logic                  w_done, w_done_d;
    logic [IDX_W-1:0]      aw_idx, aw_idx_d;
    logic [DATA_WIDTH-1:0] w_data, w_data_d;
    logic [STRB_W-1:0]     w_strb, w_strb_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [NUM_RW-1:0]     wr_pulse_d;
    logic                  awready_d, wready_d, bvalid_d;
    logic [1:0]            bresp_d;

    logic                  arready_d, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;

    logic                  aw_fire, w_fire, ar_fire;
    logic [IDX_W-1:0]      wr_idx;
    logic [31:0]           wr_idx32, rd_idx32;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_ok;

    // PROT and sub-word address bits carry no meaning for this register file
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign ctrl_out = ctrl_q;

    // Write path: AW and W latch independently; commit happens on the edge the second one lands
    always_comb begin
        wr_state_d = wr_state;
        aw_done_d  = aw_done;
        w_done_d   = w_done;
        aw_idx_d   = aw_idx;
        w_data_d   = w_data;
        w_strb_d   = w_strb;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        bvalid_d   = S_AXI_BVALID;
        bresp_d    = S_AXI_BRESP;

        aw_fire  = S_AXI_AWVALID && S_AXI_AWREADY;
        w_fire   = S_AXI_WVALID && S_AXI_WREADY;
        wr_idx   = aw_done ? aw_idx : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        wr_data  = w_done ? w_data : S_AXI_WDATA;
        wr_strb  = w_done ? w_strb : S_AXI_WSTRB;
        wr_idx32 = 32'(wr_idx);
        wr_ok    = (wr_idx32 < NUM_RW);

        case (wr_state)
            WR_IDLE: begin
                if (aw_fire) begin
                    aw_done_d = 1'b1;
                    aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                end
                if (w_fire) begin
                    w_done_d = 1'b1;
                    w_data_d = S_AXI_WDATA;
                    w_strb_d = S_AXI_WSTRB;
                end
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = WR_RESP;
                    for (int unsigned r = 0; r < NUM_RW; r++) begin
                        if (wr_ok && (wr_idx32 == r)) begin
                            wr_pulse_d[r] = 1'b1;
                            for (int unsigned b = 0; b < STRB_W; b++) begin
                                if (wr_strb[b]) begin
                                    ctrl_d[r*DATA_WIDTH + b*8 +: 8] = wr_data[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        awready_d = (wr_state_d == WR_IDLE) && !aw_done_d;
        wready_d  = (wr_state_d == WR_IDLE) && !w_done_d;
    end

    // Read path: registers on AR handshake, so a same-edge commit is not visible to this read
    always_comb begin
        rd_state_d = rd_state;
        rvalid_d   = S_AXI_RVALID;
        rdata_d    = S_AXI_RDATA;
        rresp_d    = S_AXI_RRESP;

        ar_fire  = S_AXI_ARVALID && S_AXI_ARREADY;
        rd_idx32 = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

        case (rd_state)
            RD_IDLE: begin
                if (ar_fire) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rd_state_d = RD_DATA;
                    for (int unsigned r = 0; r < NUM_REGS; r++) begin
                        if (rd_idx32 == r) begin
                            rresp_d = RESP_OKAY;
                            if (r < NUM_RW) begin
                                rdata_d = ctrl_q[r*DATA_WIDTH +: DATA_WIDTH];
                            end else begin
                                rdata_d = status_in[(r - NUM_RW)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state      <= WR_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            ctrl_q        <= '0;
            wr_pulse      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            wr_state      <= wr_state_d;
            aw_done       <= aw_done_d;
            w_done        <= w_done_d;
            aw_idx        <= aw_idx_d;
            w_data        <= w_data_d;
            w_strb        <= w_strb_d;
            ctrl_q        <= ctrl_d;
            wr_pulse      <= wr_pulse_d;
            S_AXI_AWREADY <= awready_d;
            S_AXI_WREADY  <= wready_d;
            S_AXI_BVALID  <= bvalid_d;
            S_AXI_BRESP   <= bresp_d;
            rd_state      <= rd_state_d;
            S_AXI_ARREADY <= arready_d;
            S_AXI_RVALID  <= rvalid_d;
            S_AXI_RDATA   <= rdata_d;
            S_AXI_RRESP   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave at default parameters (32-bit, 8 regs, 2 read-only).
module tb_axil_regfile_slave;

    logic        ACLK;
    logic        ARESETN;
    logic [7:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [7:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [63:0] status_in;
    logic [191:0] ctrl_out;
    logic [5:0]  wr_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt [6] = '{default: 0};

    axil_regfile_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .status_in(status_in), .ctrl_out(ctrl_out), .wr_pulse(wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Counts high cycles of each wr_pulse bit
    always @(negedge ACLK) begin
        for (int i = 0; i < 6; i++) begin
            if (wr_pulse[i]) pulse_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic int pulse_total();
        int s = 0;
        for (int i = 0; i < 6; i++) s += pulse_cnt[i];
        return s;
    endfunction

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_p, w_p, aw_f, w_f;
        int   n;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        aw_p = 1'b1; w_p = 1'b1; n = 0;
        while ((aw_p || w_p) && n < 20) begin
            aw_f = aw_p && S_AXI_AWREADY;
            w_f  = w_p && S_AXI_WREADY;
            step();
            if (aw_f) begin aw_p = 1'b0; S_AXI_AWVALID = 1'b0; end
            if (w_f)  begin w_p = 1'b0;  S_AXI_WVALID = 1'b0;  end
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin step(); n++; end
        check("wr_bvalid_seen", 64'(S_AXI_BVALID), 64'(1));
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1; step(); S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_f;
        int   n;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        ar_f = 1'b0; n = 0;
        while (!ar_f && n < 20) begin
            ar_f = S_AXI_ARREADY;
            step();
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin step(); n++; end
        check("rd_rvalid_seen", 64'(S_AXI_RVALID), 64'(1));
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1; step(); S_AXI_RREADY = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;
    int          snap;

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        status_in = '0;

        // Reset values
        #3;
        check("rst_awready", 64'(S_AXI_AWREADY), 64'(0));
        check("rst_wready",  64'(S_AXI_WREADY),  64'(0));
        check("rst_arready", 64'(S_AXI_ARREADY), 64'(0));
        check("rst_bvalid",  64'(S_AXI_BVALID),  64'(0));
        check("rst_rvalid",  64'(S_AXI_RVALID),  64'(0));
        check("rst_bresp",   64'(S_AXI_BRESP),   64'(0));
        check("rst_rresp",   64'(S_AXI_RRESP),   64'(0));
        check("rst_rdata",   64'(S_AXI_RDATA),   64'(0));
        check("rst_ctrl",    64'(ctrl_out[63:0]), 64'(0));
        check("rst_pulse",   64'(wr_pulse),      64'(0));
        step(); step();
        ARESETN = 1'b1;
        step(); step();
        check("idle_awready", 64'(S_AXI_AWREADY), 64'(1));
        check("idle_arready", 64'(S_AXI_ARREADY), 64'(1));

        // Basic writes and read-back
        for (int i = 0; i < 4; i++) begin
            axi_write(8'(4*i), 32'(i + 1), 4'hF, resp);
            check("t1_bresp", 64'(resp), 64'(0));
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(4*i), rd, resp);
            check("t1_rdata", 64'(rd), 64'(i + 1));
            check("t1_rresp", 64'(resp), 64'(0));
        end
        for (int i = 0; i < 6; i++) check("t1_pulse_cnt", 64'(pulse_cnt[i]), (i < 4) ? 64'(1) : 64'(0));

        // Byte strobes
        axi_write(8'h00, 32'hAABB_CCDD, 4'hF, resp);
        axi_write(8'h00, 32'h1122_3344, 4'b0101, resp);
        check("t2_bresp", 64'(resp), 64'(0));
        axi_read(8'h00, rd, resp);
        check("t2_rdata", 64'(rd), 64'h0000_0000_AA22_CC44);
        check("t2_ctrl", 64'(ctrl_out[63:0]), 64'h0000_0002_AA22_CC44);

        // Illegal accesses and read-only status
        snap = pulse_total();
        axi_write(8'h20, 32'h0BAD_0BAD, 4'hF, resp);
        check("t3_oor_bresp", 64'(resp), 64'(2));
        axi_read(8'h20, rd, resp);
        check("t3_oor_rdata", 64'(rd), 64'(0));
        check("t3_oor_rresp", 64'(resp), 64'(2));
        axi_write(8'h18, 32'hDEAD_DEAD, 4'hF, resp);
        check("t3_ro_bresp", 64'(resp), 64'(2));
        step();
        check("t3_no_pulse", 64'(pulse_total()), 64'(snap));
        status_in = {32'h1234_5678, 32'h0000_CAFE};
        axi_read(8'h18, rd, resp);
        check("t3_ro0_rdata", 64'(rd), 64'h0000_CAFE);
        check("t3_ro0_rresp", 64'(resp), 64'(0));
        axi_read(8'h1C, rd, resp);
        check("t3_ro1_rdata", 64'(rd), 64'h1234_5678);
        axi_read(8'h05, rd, resp);
        check("t3_lowbits_rdata", 64'(rd), 64'(2));

        // W three cycles ahead of AW, then BREADY backpressure
        S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        step(); step();
        check("t4_wready_latched", 64'(S_AXI_WREADY), 64'(0));
        check("t4_no_bvalid",      64'(S_AXI_BVALID), 64'(0));
        check("t4_no_commit",      64'(pulse_cnt[2]), 64'(1));
        S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
        check("t4_awready", 64'(S_AXI_AWREADY), 64'(1));
        step();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_bvalid",  64'(S_AXI_BVALID),  64'(1));
            check("t4_hold_bresp",   64'(S_AXI_BRESP),   64'(0));
            check("t4_hold_awready", 64'(S_AXI_AWREADY), 64'(0));
            check("t4_hold_wready",  64'(S_AXI_WREADY),  64'(0));
            step();
        end
        check("t4_single_commit", 64'(pulse_cnt[2]), 64'(2));
        S_AXI_BREADY = 1'b1; step(); S_AXI_BREADY = 1'b0;
        check("t4_bvalid_drop", 64'(S_AXI_BVALID), 64'(0));
        axi_read(8'h08, rd, resp);
        check("t4_rdata", 64'(rd), 64'h55);

        // RREADY backpressure: status changes after AR must not leak into RDATA
        S_AXI_ARADDR = 8'h18; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_ARVALID = 1'b0;
        check("t4_rvalid", 64'(S_AXI_RVALID), 64'(1));
        status_in[31:0] = 32'h0000_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_hold_rdata",  64'(S_AXI_RDATA),  64'h0000_CAFE);
            check("t4_hold_rvalid", 64'(S_AXI_RVALID), 64'(1));
        end
        S_AXI_RREADY = 1'b1; step(); S_AXI_RREADY = 1'b0;
        check("t4_rvalid_drop", 64'(S_AXI_RVALID), 64'(0));
        check("t4_arready_back", 64'(S_AXI_ARREADY), 64'(1));

        // Same-edge AR and commit to reg1
        axi_write(8'h04, 32'h5, 4'hF, resp);
        check("t5_rdy_aw", 64'(S_AXI_AWREADY), 64'(1));
        check("t5_rdy_w",  64'(S_AXI_WREADY),  64'(1));
        check("t5_rdy_ar", 64'(S_AXI_ARREADY), 64'(1));
        S_AXI_AWADDR = 8'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("t5_bvalid", 64'(S_AXI_BVALID), 64'(1));
        check("t5_rvalid", 64'(S_AXI_RVALID), 64'(1));
        check("t5_old_rdata", 64'(S_AXI_RDATA), 64'(5));
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1; step();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(8'h04, rd, resp);
        check("t5_new_rdata", 64'(rd), 64'(9));

        // Reset while BVALID is pending
        S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("t6_bvalid_pend", 64'(S_AXI_BVALID), 64'(1));
        #2 ARESETN = 1'b0;
        #1;
        check("t6a_bvalid", 64'(S_AXI_BVALID),  64'(0));
        check("t6a_awready", 64'(S_AXI_AWREADY), 64'(0));
        check("t6a_wready", 64'(S_AXI_WREADY),  64'(0));
        check("t6a_arready", 64'(S_AXI_ARREADY), 64'(0));
        check("t6a_ctrl", 64'(ctrl_out[127:64]), 64'(0));
        check("t6a_ctrl_lo", 64'(ctrl_out[63:0]), 64'(0));
        step();
        ARESETN = 1'b1;
        step(); step();
        check("t6a_bvalid_after", 64'(S_AXI_BVALID), 64'(0));
        check("t6a_ctrl_after", 64'(ctrl_out[127:96]), 64'(0));

        // Reset while only W is latched: the W must be discarded
        S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        check("t6b_w_latched", 64'(S_AXI_WREADY), 64'(0));
        snap = pulse_cnt[0];
        #2 ARESETN = 1'b0;
        #1;
        check("t6b_wready_rst", 64'(S_AXI_WREADY), 64'(0));
        step();
        ARESETN = 1'b1;
        step(); step();
        check("t6b_wready_free", 64'(S_AXI_WREADY), 64'(1));
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        step(); step(); step();
        check("t6b_no_bvalid", 64'(S_AXI_BVALID), 64'(0));
        check("t6b_no_commit", 64'(ctrl_out[31:0]), 64'(0));
        check("t6b_no_pulse", 64'(pulse_cnt[0]), 64'(snap));
        S_AXI_WDATA = 32'h88; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        check("t6b_bvalid", 64'(S_AXI_BVALID), 64'(1));
        check("t6b_bresp", 64'(S_AXI_BRESP), 64'(0));
        S_AXI_BREADY = 1'b1; step(); S_AXI_BREADY = 1'b0;
        check("t6b_ctrl", 64'(ctrl_out[31:0]), 64'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
